// File: rtl/moxie_ifetch_wb.sv
// Wishbone instruction-fetch master feeding a DEPTH-entry prefetch FIFO; one word per clock under single-cycle acks.
// Ack to ins_valid_o takes 1 cycle; a new bus cycle only starts with a free FIFO slot, and a branch flushes everything.
module moxie_ifetch_wb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00001000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_W-1:0]     branch_target_i,
  input  logic                  ins_ready_i,
  output logic                  ins_valid_o,
  output logic [DATA_W-1:0]     ins_data_o,
  output logic [ADDR_W-1:0]     ins_addr_o,
  output logic                  ins_fault_o,
  output logic [ADDR_W-1:0]     wb_I_adr_o,
  output logic                  wb_I_cyc_o,
  output logic                  wb_I_stb_o,
  output logic                  wb_I_we_o,
  output logic [DATA_W/8-1:0]   wb_I_sel_o,
  input  logic [DATA_W-1:0]     wb_I_dat_i,
  input  logic                  wb_I_ack_i,
  input  logic                  wb_I_err_i
);
  localparam int BYTES = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(BYTES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_dat_q [DEPTH];
  logic [DATA_W-1:0]   mem_dat_d [DEPTH];
  logic [ADDR_W-1:0]   mem_adr_q [DEPTH];
  logic [ADDR_W-1:0]   mem_adr_d [DEPTH];
  logic                mem_err_q [DEPTH];
  logic                mem_err_d [DEPTH];

  logic open, term, push, pop;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_dat_d = mem_dat_q;
    mem_adr_d = mem_adr_q;
    mem_err_d = mem_err_q;

    open = (state_q != IDLE);
    term = open & (wb_I_ack_i | wb_I_err_i);
    pop  = (cnt_q != '0) & ins_ready_i;
    // A word terminating alongside a branch belongs to the stale stream.
    push = (state_q == FETCH) & term & ~branch_flag_i;

    if (push) begin
      mem_dat_d[wr_q] = wb_I_dat_i;
      mem_adr_d[wr_q] = adr_q;
      mem_err_d[wr_q] = wb_I_err_i;
      wr_d            = wr_q + 1'b1;
      ptr_d           = adr_q + STEP;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (branch_flag_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ptr_d = branch_target_i & ALIGN;
    end

    case (state_q)
      IDLE: begin
        if (branch_flag_i || (cnt_q < DEPTH_C)) state_d = FETCH;
      end
      FETCH: begin
        if (branch_flag_i)  state_d = term ? FETCH : DISCARD;
        else if (term)      state_d = (cnt_d < DEPTH_C) ? FETCH : IDLE;
      end
      DISCARD: begin
        if (term) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // Address only moves when no cycle is left open across the edge.
    adr_d = (open && !term) ? adr_q : ptr_d;
    cyc_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= RESET_PC;
      ptr_q   <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat_q[i] <= '0;
        mem_adr_q[i] <= '0;
        mem_err_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      mem_dat_q <= mem_dat_d;
      mem_adr_q <= mem_adr_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign ins_valid_o = (cnt_q != '0);
  assign ins_data_o  = mem_dat_q[rd_q];
  assign ins_addr_o  = mem_adr_q[rd_q];
  assign ins_fault_o = mem_err_q[rd_q];
  assign wb_I_adr_o  = adr_q;
  assign wb_I_cyc_o  = cyc_q;
  assign wb_I_stb_o  = cyc_q;
  assign wb_I_we_o   = 1'b0;
  assign wb_I_sel_o  = '1;
endmodule
